// File: rtl/serial_tx.sv
// Byte-to-serial UART transmitter (8N1): a small byte FIFO feeds a shift register that is sent LSB-first.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module serial_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic                          dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    DEPTH    = CW'(FIFO_DEPTH);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_reg;
    logic [CNT_W-1:0]   clk_cnt_reg;
    logic [2:0]         bit_cnt_reg;
    logic [7:0]         shift_reg;
    logic               dout_reg;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
`ifdef SERIAL_TX_PARITY_EN
    logic               parity_reg;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [7:0]         head;
    logic               push;
    logic               pop;
    logic               bit_end;

    assign din_ready  = (count_reg != DEPTH);
    assign push       = din_valid && din_ready;
    assign bit_end    = (clk_cnt_reg == CNT_LAST);
    // The shifter reloads either from idle or on the very last stop cycle, so frames abut.
    assign pop        = (count_reg != '0) &&
                        ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end));
    assign head       = mem[rd_ptr_reg];
    assign busy       = (state_reg != S_IDLE) || (count_reg != '0);
    assign dout       = dout_reg;
    assign fifo_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            dout_reg    <= 1'b1;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end

            case (state_reg)
                S_IDLE: begin
                    clk_cnt_reg <= '0;
                    bit_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg <= head;
`ifdef SERIAL_TX_PARITY_EN
                        parity_reg <= ^head;
`endif
                        state_reg <= S_START;
                        dout_reg  <= 1'b0;
                    end else begin
                        dout_reg  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        state_reg   <= S_DATA;
                        dout_reg    <= shift_reg[0];
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_reg <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            state_reg   <= S_PARITY;
                            dout_reg    <= parity_reg;
`else
                            state_reg   <= S_STOP;
                            dout_reg    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            dout_reg    <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        state_reg   <= S_STOP;
                        dout_reg    <= 1'b1;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg <= head;
`ifdef SERIAL_TX_PARITY_EN
                            parity_reg <= ^head;
`endif
                            state_reg <= S_START;
                            dout_reg  <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                            dout_reg  <= 1'b1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    dout_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Randomised and directed bench for serial_tx; a frame-timeline reference model predicts every output each cycle.
module tb_serial_tx;

    localparam int CPB      = 4;
    localparam int CPB_SLOW = 5208;
    localparam int DEPTH    = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       busy;
    logic [2:0] fifo_count;

    logic [7:0] din_s;
    logic       din_valid_s;
    logic       din_ready_s;
    logic       dout_s;
    logic       busy_s;
    logic [2:0] fifo_count_s;

    serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    serial_tx #(.CLKS_PER_BIT(CPB_SLOW), .FIFO_DEPTH(DEPTH)) u_dut_slow (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_s),
        .din_valid  (din_valid_s),
        .din_ready  (din_ready_s),
        .dout       (dout_s),
        .busy       (busy_s),
        .fifo_count (fifo_count_s)
    );

    int unsigned check_cnt = 0;
    int unsigned fail_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queued bytes plus a timeline position inside the current frame.
    byte unsigned q[$];
    bit           m_active = 1'b0;
    int           m_t      = 0;
    logic [10:0]  m_frame  = '1;

    function automatic logic [10:0] build_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef SERIAL_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic model_step(output bit acc);
        acc = 1'b0;
        if (rst_n !== 1'b1) begin
            q.delete();
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            acc = din_valid && (q.size() != DEPTH);
            if (m_active) begin
                if (m_t == FLEN * CPB - 1) m_active = 1'b0;
                else                       m_t++;
            end
            if (!m_active && q.size() != 0) begin
                m_frame  = build_frame(q.pop_front());
                m_active = 1'b1;
                m_t      = 0;
            end
            if (acc) q.push_back(din);
        end
    endtask

    task automatic compare_fast();
        logic exp_dout;
        exp_dout = m_active ? m_frame[m_t / CPB] : 1'b1;
        check_eq("dout",       32'(dout),       32'(exp_dout));
        check_eq("busy",       32'(busy),       32'(m_active || q.size() != 0));
        check_eq("din_ready",  32'(din_ready),  32'(q.size() != DEPTH));
        check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
    endtask

    task automatic tick(output bit acc);
        @(posedge clk);
        model_step(acc);
        if (acc) $display("push byte=0x%02h queued=%0d", din, q.size());
        #1;
        compare_fast();
    endtask

    task automatic push_byte(input logic [7:0] b, input string tag);
        bit acc;
        int n;
        din       = b;
        din_valid = 1'b1;
        acc       = 1'b0;
        n         = 0;
        while (!acc && n < 400) begin
            tick(acc);
            n++;
        end
        din_valid = 1'b0;
        if (!acc) check_eq(tag, 32'(din_ready), 32'(1));
    endtask

    task automatic drain(input int limit);
        bit acc;
        int n;
        n         = 0;
        din_valid = 1'b0;
        while ((busy === 1'b1 || m_active || q.size() != 0) && n < limit) begin
            tick(acc);
            n++;
        end
        check_eq("drain_done", 32'(busy), 32'(0));
    endtask

    initial begin
        bit          acc;
        int          n;
        logic [10:0] exp_slow;
        logic        exp_bit;

        rst_n       = 1'b0;
        din         = 8'h5A;
        din_valid   = 1'b1;
        din_s       = 8'h5A;
        din_valid_s = 1'b1;
        repeat (3) tick(acc);
        check_eq("rst_dout",       32'(dout),         32'(1));
        check_eq("rst_busy",       32'(busy),         32'(0));
        check_eq("rst_count",      32'(fifo_count),   32'(0));
        check_eq("rst_slow_dout",  32'(dout_s),       32'(1));
        check_eq("rst_slow_busy",  32'(busy_s),       32'(0));
        check_eq("rst_slow_count", 32'(fifo_count_s), 32'(0));
        check_eq("rst_slow_ready", 32'(din_ready_s),  32'(1));
        din_valid   = 1'b0;
        din_valid_s = 1'b0;
        rst_n       = 1'b1;

        // Full-rate single frame of 0x63 on the slow instance.
        din_s       = 8'h63;
        din_valid_s = 1'b1;
        tick(acc);
        din_valid_s = 1'b0;
        $display("slow push byte=0x63");
        check_eq("slow_count_after_push", 32'(fifo_count_s), 32'(1));
        check_eq("slow_idle_at_accept",   32'(dout_s),       32'(1));
        exp_slow = build_frame(8'h63);
        for (int k = 1; k <= FLEN * CPB_SLOW + 1; k++) begin
            tick(acc);
            exp_bit = (k <= FLEN * CPB_SLOW) ? exp_slow[(k - 1) / CPB_SLOW] : 1'b1;
            check_eq("slow_dout", 32'(dout_s), 32'(exp_bit));
            if (k == FLEN * CPB_SLOW) check_eq("slow_busy_last", 32'(busy_s), 32'(1));
        end
        check_eq("slow_busy_done", 32'(busy_s), 32'(0));

        // Back-to-back frames.
        din = 8'hA5; din_valid = 1'b1; tick(acc);
        din = 8'h3C; tick(acc);
        din_valid = 1'b0;
        drain(4 * FLEN * CPB);

        // Fill the FIFO: five in flight, sixth waits for a pop.
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), "full_push_timeout");
        check_eq("full_ready", 32'(din_ready),  32'(0));
        check_eq("full_count", 32'(fifo_count), 32'(4));
        push_byte(8'h15, "full_sixth_timeout");
        drain(8 * FLEN * CPB);

        // Parity-relevant bytes.
        push_byte(8'h63, "par_push_timeout");
        drain(3 * FLEN * CPB);
        push_byte(8'h07, "par_push_timeout");
        drain(3 * FLEN * CPB);

        // Random traffic; the source holds a byte until it is taken.
        din_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!din_valid && ($urandom % 3) == 0) begin
                din       = 8'($urandom);
                din_valid = 1'b1;
            end
            tick(acc);
            if (acc) din_valid = 1'b0;
        end
        drain(8 * FLEN * CPB);

        // Reset in the middle of data bit 3 of 0xFF with two bytes queued.
        din = 8'hFF; din_valid = 1'b1; tick(acc);
        din = 8'h11; tick(acc);
        din = 8'h22; tick(acc);
        din_valid = 1'b0;
        n = 0;
        while (!(m_active && (m_t / CPB) == 4) && n < 100) begin
            tick(acc);
            n++;
        end
        check_eq("midrst_in_bit3", 32'(dout),       32'(1));
        check_eq("midrst_queued",  32'(fifo_count), 32'(2));
        rst_n = 1'b0;
        tick(acc);
        rst_n = 1'b1;
        check_eq("midrst_dout",  32'(dout),       32'(1));
        check_eq("midrst_count", 32'(fifo_count), 32'(0));
        check_eq("midrst_busy",  32'(busy),       32'(0));
        repeat (3 * FLEN * CPB) tick(acc);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-to-serial UART transmitter: the transmit end of the 8N1 serial link whose receive side samples `din` in `serial_transceiver`. Accepts bytes over a valid/ready handshake into a small FIFO and shifts each byte out LSB-first as start + 8 data + stop bits, each bit held for a fixed clock count. Default timing gives 5208 clocks per bit (9600 baud at 50 MHz), matching the existing receiver and its bench.

## Interface
- `CLKS_PER_BIT`, 5208: clocks per serial bit; legal range ≥2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `clk`  input  1: system clock; all logic on its rising edge.
- `rst_n`  input  1: reset, synchronous, active-low.
- `din`  input  8: byte to send.
- `din_valid`  input  1: `din` is valid this cycle.
- `din_ready`  output  1: FIFO can accept a byte this cycle.
- `dout`  output  1: serial line; idles high.
- `busy`  output  1: frame in progress or FIFO non-empty.
- `fifo_count`  output  clog2(FIFO_DEPTH)+1: bytes currently queued, excluding the one being shifted.

## Operation
- Reset values: `dout`=1, `busy`=0, `din_ready`=1, `fifo_count`=0. FSM state is IDLE, bit counter and clock counter are 0, and FIFO pointers are cleared.
- Push: on a rising edge with `din_valid`&&`din_ready`, `din` is written at the tail. `din_ready` = (`fifo_count` != FIFO_DEPTH) and is registered-state only; a pop in the same cycle does not raise it.
- Pop: occurs in IDLE when the FIFO is non-empty, or in the last STOP cycle when the FIFO is non-empty. The popped byte loads the shift register. A push and a pop in the same cycle leave `fifo_count` unchanged.
- FSM:
  - IDLE: `dout`=1. Pop moves to START.
  - START: `dout`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `dout`=shift[0]. The register shifts right every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if enabled, else STOP.
  - PARITY (macro only): `dout`=parity for CLKS_PER_BIT cycles, then STOP.
  - STOP: `dout`=1 for CLKS_PER_BIT cycles. Then go to START (FIFO non-empty, pop) or IDLE.
- `dout` is a registered output, glitch-free, and changes only on bit boundaries.
- `busy` = (state != IDLE) || (`fifo_count` != 0).
- Clock counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Bit counter counts 0..7.
- `din_valid` while `din_ready`=0 is ignored; the byte is dropped and the source must hold it.
- Reset asserted mid-frame aborts the frame. Next edge: `dout`=1 and the FIFO is emptied.

## Timing
- Byte accepted at edge N into an empty FIFO while IDLE: `fifo_count`=1 after N. At N+1 the byte pops, and `dout` is low from N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames have no idle gap: the next start bit begins the cycle after the previous stop bit's last cycle.
- Throughput: one byte per frame. FIFO_DEPTH+1 bytes can be in flight (FIFO plus shifter).

## Configuration
- `SERIAL_TX_PARITY_EN` defined: a PARITY state is inserted after DATA. The bit sent is the XOR of the 8 data bits (even parity), and the frame is 11 bits.
- Undefined: no PARITY state or parity logic, and the frame is 10 bits (8N1).

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `din_valid`=1. Required: `dout`=1, `busy`=0, `fifo_count`=0, nothing queued.
- Single byte 0x63, CLKS_PER_BIT=5208: `dout` sequence is 0,1,1,0,0,0,1,1,0,1, each bit 5208 cycles. Start falls one cycle after acceptance. `busy` drops after 52080 cycles.
- Back-to-back, CLKS_PER_BIT=4: push 0xA5 then 0x3C on consecutive cycles. Required: two contiguous 40-cycle frames, with the second start bit immediately after the first stop bit.
- FIFO full, CLKS_PER_BIT=4, FIFO_DEPTH=4: push 6 bytes continuously. Required:
  - bytes 1–5 accepted (one shifting, four queued);
  - `din_ready`=0 with `fifo_count`=4;
  - byte 6 accepted only after the next pop;
  - all bytes are sent in push order.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3 of 0xFF with 2 bytes queued. Required: `dout`=1 next edge, `fifo_count`=0, and no further frames.
- `SERIAL_TX_PARITY_EN`: send 0x63 (four ones). Required: parity bit 0, frame 0,1,1,0,0,0,1,1,0,0,1. Then send 0x07: parity bit 1.
